// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants for the monitor timing generator family.
//   - Region widths for the 640x480@60 and 800x600@60 modes. Each axis is
//     described by its active, front porch, sync and back porch widths.
//   - axis_total(): the full line/frame length built from the four widths.
//   - CW_DEFAULT: default counter/coordinate width. It is wide enough for
//     every mode listed here.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Default counter width: 2^11 = 2048 exceeds every total used below.
  localparam int CW_DEFAULT = 11;

  // 640x480 @ 60 Hz (25.175 MHz nominal pixel rate).
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;

  // 800x600 @ 60 Hz (40 MHz nominal pixel rate). Both syncs are active high.
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FRONT  = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BACK   = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FRONT  = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BACK   = 23;

  // Total positions on one axis. The region order is sync, back porch,
  // active, front porch, but the order does not affect the total.
  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return sync + back + active + front;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
//   Position counter for one display axis (horizontal or vertical).
//   The axis is laid out as: sync | back porch | active | front porch,
//   with count 0 at the first sync position.
//
//   Ports
//     clock, reset_n : system clock, asynchronous active-low reset
//     step           : advance the count on this clock edge
//     wrap_en        : lets a roll-over be reported on 'wrap'. The count
//                      itself always rolls over from TOTAL-1 to 0.
//     count          : registered raw position, 0..TOTAL-1
//     coord          : registered active-area coordinate. It holds its last
//                      value outside the active range.
//     sync           : registered sync at the configured polarity
//     active         : active-range decode of the count being loaded on
//                      this edge. The parent registers this together with
//                      the other axis.
//     wrap           : this edge takes the count from TOTAL-1 back to 0
// ---------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE     = VGA640_H_ACTIVE,
  parameter int FRONT      = VGA640_H_FRONT,
  parameter int SYNC       = VGA640_H_SYNC,
  parameter int BACK       = VGA640_H_BACK,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int CW         = CW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          step,
  input  logic          wrap_en,
  output logic [CW-1:0] count,
  output logic [CW-1:0] coord,
  output logic          sync,
  output logic          active,
  output logic          wrap
);

  localparam int            TOTAL       = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam logic [CW-1:0] LAST_C      = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_END_C  = CW'(SYNC);
  localparam logic [CW-1:0] ACT_FIRST_C = CW'(SYNC + BACK);
  localparam logic [CW-1:0] ACT_LAST_C  = CW'(SYNC + BACK + ACTIVE - 1);
  localparam logic [CW-1:0] ONE_C       = {{(CW-1){1'b0}}, 1'b1};
  localparam logic          SYNC_ON     = ACTIVE_LOW ? 1'b0 : 1'b1;

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] coord_d;
  logic [CW-1:0] coord_q;
  logic          sync_d;
  logic          sync_q;
  logic          at_last_s;
  logic          active_s;

  // Next raw count: advance on step and roll over after the last position.
  always_comb begin
    at_last_s = (count_q == LAST_C);
    if (step) begin
      if (at_last_s) begin
        count_d = {CW{1'b0}};
      end else begin
        count_d = count_q + ONE_C;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Decode sync, active and coordinate from the next count. This keeps the
  // registered outputs aligned with the registered count, with no skew.
  always_comb begin
    if (count_d < SYNC_END_C) begin
      sync_d = SYNC_ON;
    end else begin
      sync_d = ~SYNC_ON;
    end

    if ((count_d >= ACT_FIRST_C) && (count_d <= ACT_LAST_C)) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end

    // Outside the active range the coordinate keeps its last value. Pixel
    // logic that ignores the active flag then reads a stable edge pixel.
    if (active_s) begin
      coord_d = count_d - ACT_FIRST_C;
    end else begin
      coord_d = coord_q;
    end
  end

  // Axis state registers. Reset places the axis at count 0, which lies
  // inside the sync region, so sync starts at its active level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= {CW{1'b0}};
      coord_q <= {CW{1'b0}};
      sync_q  <= SYNC_ON;
    end else begin
      count_q <= count_d;
      coord_q <= coord_d;
      sync_q  <= sync_d;
    end
  end

  assign count  = count_q;
  assign coord  = coord_q;
  assign sync   = sync_q;
  assign active = active_s;
  assign wrap   = step & wrap_en & at_last_s;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised monitor timing generator. It runs on the system clock and
//   advances one pixel on every edge where pix_en is high. Every output is
//   registered and decoded from the next-state counts, so all outputs match
//   the hcount/vcount shown in the same cycle.
//
//   Ports
//     clock, reset_n  : system clock, asynchronous active-low reset
//     pix_en          : pixel strobe
//     hcount, vcount  : raw positions, 0..H_TOTAL-1 / 0..V_TOTAL-1
//     x, y            : active-area coordinates. They hold outside the
//                       active range.
//     hsync, vsync    : syncs at the polarity set by *_ACTIVE_LOW
//     at_display_area : (hcount, vcount) is inside the active region
//     line_start      : one-clock pulse when hcount has just become 0
//     frame_start     : one-clock pulse when both counts have just become 0
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE         = VGA640_H_ACTIVE,
  parameter int H_FRONT          = VGA640_H_FRONT,
  parameter int H_SYNC           = VGA640_H_SYNC,
  parameter int H_BACK           = VGA640_H_BACK,
  parameter int V_ACTIVE         = VGA640_V_ACTIVE,
  parameter int V_FRONT          = VGA640_V_FRONT,
  parameter int V_SYNC           = VGA640_V_SYNC,
  parameter int V_BACK           = VGA640_V_BACK,
  parameter bit HSYNC_ACTIVE_LOW = 1'b1,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int CW               = CW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          at_display_area,
  output logic          line_start,
  output logic          frame_start
);

  logic [CW-1:0] h_count_s;
  logic [CW-1:0] h_coord_s;
  logic          h_sync_s;
  logic          h_active_s;
  logic          h_wrap_s;
  logic [CW-1:0] v_count_s;
  logic [CW-1:0] v_coord_s;
  logic          v_sync_s;
  logic          v_active_s;
  logic          v_wrap_s;
  logic          v_step_s;

  logic          display_d;
  logic          display_q;
  logic          line_start_d;
  logic          line_start_q;
  logic          frame_start_d;
  logic          frame_start_q;

  // The vertical axis moves only on the edge where the horizontal axis
  // rolls over. A line therefore always finishes before vcount changes.
  assign v_step_s = pix_en & h_wrap_s;

  vga_axis_counter #(
    .ACTIVE     (H_ACTIVE),
    .FRONT      (H_FRONT),
    .SYNC       (H_SYNC),
    .BACK       (H_BACK),
    .ACTIVE_LOW (HSYNC_ACTIVE_LOW),
    .CW         (CW)
  ) u_h_axis (
    .clock   (clock),
    .reset_n (reset_n),
    .step    (pix_en),
    .wrap_en (1'b1),
    .count   (h_count_s),
    .coord   (h_coord_s),
    .sync    (h_sync_s),
    .active  (h_active_s),
    .wrap    (h_wrap_s)
  );

  vga_axis_counter #(
    .ACTIVE     (V_ACTIVE),
    .FRONT      (V_FRONT),
    .SYNC       (V_SYNC),
    .BACK       (V_BACK),
    .ACTIVE_LOW (VSYNC_ACTIVE_LOW),
    .CW         (CW)
  ) u_v_axis (
    .clock   (clock),
    .reset_n (reset_n),
    .step    (v_step_s),
    .wrap_en (1'b1),
    .count   (v_count_s),
    .coord   (v_coord_s),
    .sync    (v_sync_s),
    .active  (v_active_s),
    .wrap    (v_wrap_s)
  );

  // Next-state display flag and start pulses. The pulses come only from an
  // enabled wrap edge. They clear on any idle edge, and release from reset
  // does not produce one.
  always_comb begin
    display_d     = h_active_s & v_active_s;
    line_start_d  = h_wrap_s;
    frame_start_d = h_wrap_s & v_wrap_s;
  end

  // Registers for the flags that combine both axes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      display_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      display_q     <= display_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount          = h_count_s;
  assign vcount          = v_count_s;
  assign x               = h_coord_s;
  assign y               = v_coord_s;
  assign hsync           = h_sync_s;
  assign vsync           = v_sync_s;
  assign at_display_area = display_q;
  assign line_start      = line_start_q;
  assign frame_start     = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three generators share one clock, reset and strobe:
//     dut0 : default 640x480, both syncs active low
//     dut1 : 800-wide horizontal timing, hsync active high
//     dut2 : tiny 13x8 raster, both syncs active high (short frames)
//   The reference model works from the number of enabled edges since reset.
//   It derives every output from that count with division and remainder.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [10:0] x;
    logic [10:0] y;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        ls;
    logic        fs;
  } out_t;

  localparam int HA_C [3] = '{640, 800, 6};
  localparam int HF_C [3] = '{16, 40, 2};
  localparam int HS_C [3] = '{96, 128, 3};
  localparam int HB_C [3] = '{48, 88, 2};
  localparam int VA_C [3] = '{480, 480, 4};
  localparam int VF_C [3] = '{10, 10, 1};
  localparam int VS_C [3] = '{2, 2, 2};
  localparam int VB_C [3] = '{33, 33, 1};
  localparam bit HLOW_C [3] = '{1'b1, 1'b0, 1'b0};
  localparam bit VLOW_C [3] = '{1'b1, 1'b1, 1'b0};

  logic        clock;
  logic        reset_n;
  logic        pix_en;
  logic [10:0] hc [3];
  logic [10:0] vc [3];
  logic [10:0] xx [3];
  logic [10:0] yy [3];
  logic        hs [3];
  logic        vs [3];
  logic        de [3];
  logic        ls [3];
  logic        fs [3];

  int n_edges;   // enabled edges since the last reset
  bit last_en;   // previous clock edge was an enabled, out-of-reset edge
  int n_cmp;
  int n_fail;

  vga_timing_gen u_dut0 (
    .clock(clock), .reset_n(reset_n), .pix_en(pix_en),
    .hcount(hc[0]), .vcount(vc[0]), .x(xx[0]), .y(yy[0]),
    .hsync(hs[0]), .vsync(vs[0]), .at_display_area(de[0]),
    .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
    .HSYNC_ACTIVE_LOW(1'b0)
  ) u_dut1 (
    .clock(clock), .reset_n(reset_n), .pix_en(pix_en),
    .hcount(hc[1]), .vcount(vc[1]), .x(xx[1]), .y(yy[1]),
    .hsync(hs[1]), .vsync(vs[1]), .at_display_area(de[1]),
    .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_ACTIVE_LOW(1'b0), .VSYNC_ACTIVE_LOW(1'b0)
  ) u_dut2 (
    .clock(clock), .reset_n(reset_n), .pix_en(pix_en),
    .hcount(hc[2]), .vcount(vc[2]), .x(xx[2]), .y(yy[2]),
    .hsync(hs[2]), .vsync(vs[2]), .at_display_area(de[2]),
    .line_start(ls[2]), .frame_start(fs[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic out_t observed(input int k);
    return {hc[k], vc[k], xx[k], yy[k], hs[k], vs[k], de[k], ls[k], fs[k]};
  endfunction

  // Reference: the position is the enabled-edge count taken modulo the
  // raster size. Coordinates hold their last active value outside the
  // active range, which is ACTIVE-1 once a full active span has passed.
  function automatic out_t expected(input int k);
    out_t e;
    int ht, vt, h, v, line, frame, hst, hsp, vst, vsp;
    bit hin, vin;
    ht    = HS_C[k] + HB_C[k] + HA_C[k] + HF_C[k];
    vt    = VS_C[k] + VB_C[k] + VA_C[k] + VF_C[k];
    h     = n_edges % ht;
    line  = n_edges / ht;
    v     = line % vt;
    frame = line / vt;
    hst   = HS_C[k] + HB_C[k];
    hsp   = hst + HA_C[k] - 1;
    vst   = VS_C[k] + VB_C[k];
    vsp   = vst + VA_C[k] - 1;
    hin   = (h >= hst) && (h <= hsp);
    vin   = (v >= vst) && (v <= vsp);
    e.hcount = 11'(h);
    e.vcount = 11'(v);
    if (hin) e.x = 11'(h - hst);
    else if (h > hsp || line > 0) e.x = 11'(HA_C[k] - 1);
    else e.x = 11'd0;
    if (vin) e.y = 11'(v - vst);
    else if (v > vsp || frame > 0) e.y = 11'(VA_C[k] - 1);
    else e.y = 11'd0;
    e.hsync = (h < HS_C[k]) ? ~HLOW_C[k] : HLOW_C[k];
    e.vsync = (v < VS_C[k]) ? ~VLOW_C[k] : VLOW_C[k];
    e.de    = hin && vin;
    e.ls    = last_en && (n_edges > 0) && (h == 0);
    e.fs    = last_en && (n_edges > 0) && (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("h=%0d v=%0d x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                     o.hcount, o.vcount, o.x, o.y, o.hsync, o.vsync, o.de, o.ls, o.fs);
  endfunction

  // One clock: drive the strobe, advance the model at the edge, then sample
  // 1 ns after the edge.
  task automatic tick(input bit en);
    pix_en = en;
    @(posedge clock);
    if (reset_n) begin
      if (en) n_edges++;
      last_en = en;
    end else begin
      n_edges = 0;
      last_en = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    out_t g, e;
    pix_en  = 1'b0;
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    n_edges = 0;
    last_en = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      g = observed(k); e = expected(k); n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset_async dut%0d got %s want %s", k, fmt(g), fmt(e));
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick(1'b1);
      for (int k = 0; k < 3; k++) begin
        g = observed(k); e = expected(k); n_cmp++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL reset_hold dut%0d got %s want %s", k, fmt(g), fmt(e));
        end
      end
    end
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(1'b0);
      for (int k = 0; k < 3; k++) begin
        g = observed(k); e = expected(k); n_cmp++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL idle_after_reset dut%0d got %s want %s", k, fmt(g), fmt(e));
        end
      end
    end
  endtask

  task automatic test_continuous();
    out_t g, e, e0, e1, e2;
    logic [10:0] prev_h, prev_v;
    prev_h = hc[0];
    prev_v = vc[0];
    for (int c = 0; c < 29600; c++) begin
      tick(1'b1);
      for (int k = 0; k < 3; k++) begin
        g = observed(k); e = expected(k); n_cmp++;
        if (g !== e) begin
          n_fail++;
          if (n_fail <= 40) $display("FAIL cont dut%0d edge=%0d got %s want %s", k, n_edges, fmt(g), fmt(e));
        end
      end
      e0 = expected(0); e1 = expected(1); e2 = expected(2);
      if (e0.hcount == 11'd95 || e0.hcount == 11'd96) begin
        n_cmp++;
        if (hs[0] !== (e0.hcount == 11'd96)) begin
          n_fail++;
          $display("FAIL hsync_edge0 h=%0d got %b", e0.hcount, hs[0]);
        end
      end
      if (e0.vcount == 11'd35 && e0.hcount == 11'd144) begin
        n_cmp++;
        if ({de[0], xx[0], yy[0]} !== {1'b1, 11'd0, 11'd0}) begin
          n_fail++;
          $display("FAIL first_pixel de=%b x=%0d y=%0d want 1 0 0", de[0], xx[0], yy[0]);
        end
      end
      if (e0.vcount == 11'd35 && e0.hcount == 11'd783) begin
        n_cmp++;
        if ({de[0], xx[0]} !== {1'b1, 11'd639}) begin
          n_fail++;
          $display("FAIL last_pixel de=%b x=%0d want 1 639", de[0], xx[0]);
        end
      end
      if (e0.vcount == 11'd35 && e0.hcount == 11'd784) begin
        n_cmp++;
        if ({de[0], xx[0]} !== {1'b0, 11'd639}) begin
          n_fail++;
          $display("FAIL front_porch_hold de=%b x=%0d want 0 639", de[0], xx[0]);
        end
      end
      if (e1.hcount == 11'd127 || e1.hcount == 11'd128) begin
        n_cmp++;
        if (hs[1] !== (e1.hcount == 11'd127)) begin
          n_fail++;
          $display("FAIL hsync_edge1 h=%0d got %b", e1.hcount, hs[1]);
        end
      end
      if (e1.vcount == 11'd35 && (e1.hcount == 11'd215 || e1.hcount == 11'd216 ||
                                 e1.hcount == 11'd1015 || e1.hcount == 11'd1016)) begin
        n_cmp++;
        if (de[1] !== (e1.hcount == 11'd216 || e1.hcount == 11'd1015)) begin
          n_fail++;
          $display("FAIL active_range1 h=%0d de=%b", e1.hcount, de[1]);
        end
      end
      if (e2.hcount == 11'd0 && e2.vcount == 11'd0) begin
        n_cmp++;
        if ({ls[2], fs[2]} !== 2'b11) begin
          n_fail++;
          $display("FAIL frame_wrap ls=%b fs=%b want 1 1", ls[2], fs[2]);
        end
      end
      if (vc[0] !== prev_v) begin
        n_cmp++;
        if (prev_h !== 11'd799) begin
          n_fail++;
          $display("FAIL v_advance_midline prev_h=%0d got v=%0d", prev_h, vc[0]);
        end
      end
      prev_h = hc[0];
      prev_v = vc[0];
    end
  endtask

  task automatic test_quarter_rate();
    out_t g, e;
    int last0, last1;
    last0 = -1;
    last1 = -1;
    for (int c = 0; c < 9000; c++) begin
      tick((c % 4) == 0);
      for (int k = 0; k < 3; k++) begin
        g = observed(k); e = expected(k); n_cmp++;
        if (g !== e) begin
          n_fail++;
          if (n_fail <= 40) $display("FAIL quarter dut%0d edge=%0d got %s want %s", k, n_edges, fmt(g), fmt(e));
        end
      end
      if (ls[0]) begin
        if (last0 >= 0) begin
          n_cmp++;
          if (c - last0 != 3200) begin
            n_fail++;
            $display("FAIL line_period0 got %0d want 3200", c - last0);
          end
        end
        last0 = c;
      end
      if (ls[1]) begin
        if (last1 >= 0) begin
          n_cmp++;
          if (c - last1 != 4224) begin
            n_fail++;
            $display("FAIL line_period1 got %0d want 4224", c - last1);
          end
        end
        last1 = c;
      end
    end
    n_cmp++;
    if (last0 < 0) begin
      n_fail++;
      $display("FAIL quarter_no_line_start got none want at least one");
    end
  endtask

  task automatic test_random_strobe();
    out_t g, e;
    for (int c = 0; c < 4000; c++) begin
      tick($urandom_range(0, 1) == 1);
      for (int k = 0; k < 3; k++) begin
        g = observed(k); e = expected(k); n_cmp++;
        if (g !== e) begin
          n_fail++;
          if (n_fail <= 40) $display("FAIL random dut%0d edge=%0d got %s want %s", k, n_edges, fmt(g), fmt(e));
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    out_t g, e;
    int fs_cnt;
    for (int c = 0; c < 300; c++) tick(1'b1);
    #3;
    reset_n = 1'b0;
    n_edges = 0;
    last_en = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      g = observed(k); e = expected(k); n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset_mid_async dut%0d got %s want %s", k, fmt(g), fmt(e));
      end
    end
    tick(1'b1);
    tick(1'b1);
    reset_n = 1'b1;
    fs_cnt = 0;
    for (int c = 0; c < 320; c++) begin
      tick(1'b1);
      for (int k = 0; k < 3; k++) begin
        g = observed(k); e = expected(k); n_cmp++;
        if (g !== e) begin
          n_fail++;
          if (n_fail <= 40) $display("FAIL after_reset dut%0d edge=%0d got %s want %s", k, n_edges, fmt(g), fmt(e));
        end
      end
      if (fs[2]) fs_cnt++;
    end
    n_cmp++;
    if (fs_cnt != 3) begin
      n_fail++;
      $display("FAIL frame_count_after_reset got %0d want 3", fs_cnt);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    n_edges = 0;
    last_en = 1'b0;
    test_reset();
    test_continuous();
    test_quarter_rate();
    test_random_strobe();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
